mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of the EX/MEM register. Runs loads/stores
//  over a req/ack data bus with byte lanes, sign/zero extension and a timeout.
//  Selects the write-back value (ALU, LUI or load) and registers it toward WB.
//  Raises a stall while a bus access is pending. Upstream must then hold its outputs constant.
// PARAMETERS
//  TIMEOUT   255  max cycles in REQ waiting for dbus_ack before abort (1..255)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   synchronous reset, active-low (0 = reset)
//  mem_lui_sig   in   1   instruction is LUI
//  mem_MemRead   in   1   load instruction
//  mem_MemWrite  in   1   store instruction
//  mem_MemtoReg  in   1   WB value comes from memory
//  mem_RegWrite  in   1   instruction writes GPR
//  mem_alu_result in  32  effective address / ALU result
//  mem_rdata_b   in   32  store data (rt)
//  mem_opcode    in   6   MIPS opcode, selects access size/extension
//  mem_imme_num  in   32  immediate (LUI uses [15:0])
//  mem_wreg      in   5   destination register
//  stall         out  1   combinational, 1 = hold EX/MEM and earlier stages
//  dbus_req      out  1   bus request, held until ack or timeout
//  dbus_we       out  1   1 = write
//  dbus_be       out  4   byte enables
//  dbus_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  dbus_wdata    out  32  store data replicated to lanes
//  dbus_ack      in   1   access complete, sampled only while dbus_req=1
//  dbus_rdata    in   32  read data, valid with dbus_ack
//  wb_RegWrite   out  1   registered write enable to WB
//  wb_wreg       out  5   registered destination
//  wb_wdata      out  32  registered write-back value
//  addr_err      out  1   1-cycle pulse: misaligned access
//  bus_err       out  1   1-cycle pulse: timeout
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE, cnt=0, all registered outputs 0. dbus_req drops at that edge.
//  Opcodes: LB 20 LH 21 LW 23 LBU 24 LHU 25 SB 28 SH 29 SW 2B (hex).
//  Any other opcode with MemRead/MemWrite is treated as a word access.
//  Misaligned: half with a[0]=1, word with a[1:0]!=0. No bus access.
//    addr_err pulses, wb_RegWrite=0, no stall.
//  memop = (MemRead|MemWrite) & aligned.
//  FSM IDLE: stall=memop. If memop, go to REQ and clear cnt. Else WB regs load at the edge
//    (latency 1): wdata = lui_sig ? {imme[15:0],16'h0} : alu_result.
//  FSM REQ: dbus_req=1, stall=1. Bus outputs come from the held inputs. cnt increments each cycle.
//    ack=1: latch rdata lane/extension into ldata, go to DONE.
//    If cnt==TIMEOUT-1 and no ack: bus_err pulses, go to DONE with ldata=0 and write suppressed.
//    Ack and timeout in the same cycle: ack wins.
//  FSM DONE: stall=0, and WB regs load at the edge.
//    wdata = MemtoReg ? ldata : alu_result.
//    wb_RegWrite = RegWrite & ~timeout. Then go to IDLE.
//  While stall=1, the WB regs load wb_RegWrite=0 (bubble).
//  Load latency with ack in the first REQ cycle: 3 cycles from arrival to wb valid.
//  Byte lanes (little-endian): byte be=1<<a[1:0], wdata={4{b[7:0]}}.
//    Half be=a[1]?1100:0011, wdata={2{b[15:0]}}. Word be=1111. Loads drive dbus_we=0.
//    Load extension: sign for LB/LH, zero for LBU/LHU.
//  dbus_ack is ignored outside REQ. Reset in REQ aborts with no WB write or error pulse.
// TESTING
//  ADD path: MemRead=0, RegWrite=1, alu=0x1234, wreg=3 -> next cycle wb_wdata=0x1234, wb_wreg=3, stall never 1.
//  LB a=0x103, rdata=0x80AA_BBCC, ack in 1st REQ cycle -> be=1000, wb_wdata=0xFFFF_FF80 three cycles after arrival.
//  SH a=0x102, b=0x0000_BEEF -> dbus_we=1, be=1100, wdata=0xBEEF_BEEF, addr=0x100, wb_RegWrite=0.
//  LW a=0x101 -> addr_err pulses once, dbus_req stays 0, stall stays 0, wb_RegWrite=0.
//  LW, no ack, TIMEOUT=4 -> req high for 4 cycles, bus_err pulses, wb_RegWrite=0, then back to IDLE.
//  rst=0 during REQ with ack pending -> req low after that edge, all outputs 0, later ack ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_stage : MEM pipeline stage, req/ack data bus access and WB select
// Revision 1.0
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_lui_sig,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        mem_MemtoReg,
  input  logic        mem_RegWrite,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata_b,
  input  logic [5:0]  mem_opcode,
  input  logic [31:0] mem_imme_num,
  input  logic [4:0]  mem_wreg,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [31:0] ldata;
  logic        timeout_flag;

  logic        is_byte;
  logic        is_half;
  logic        is_signed;
  logic [1:0]  a_lo;
  logic        misaligned;
  logic        memop;
  logic        ack_hit;
  logic        timeout_hit;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  logic [31:0] rshift;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        unused_imme_hi;

  assign unused_imme_hi = ^mem_imme_num[31:16];
  assign a_lo      = mem_alu_result[1:0];
  assign is_byte   = (mem_opcode == OP_LB) || (mem_opcode == OP_LBU) || (mem_opcode == OP_SB);
  assign is_half   = (mem_opcode == OP_LH) || (mem_opcode == OP_LHU) || (mem_opcode == OP_SH);
  assign is_signed = (mem_opcode == OP_LB) || (mem_opcode == OP_LH);

  assign misaligned = (mem_MemRead | mem_MemWrite) &
                      (is_byte ? 1'b0 : (is_half ? a_lo[0] : (a_lo != 2'b00)));
  assign memop = (mem_MemRead | mem_MemWrite) & ~misaligned;

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    dbus_req    = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        stall = memop;
        if (memop) state_nxt = REQ;
      end
      REQ: begin
        stall    = 1'b1;
        dbus_req = 1'b1;
        // ack takes priority over an expiring counter in the same cycle
        if (dbus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = mem_rdata_b;
    if (is_byte) begin
      be_raw    = 4'b0001 << a_lo;
      wdata_raw = {4{mem_rdata_b[7:0]}};
    end else if (is_half) begin
      be_raw    = a_lo[1] ? 4'b1100 : 4'b0011;
      wdata_raw = {2{mem_rdata_b[15:0]}};
    end
  end

  assign dbus_we    = dbus_req & mem_MemWrite;
  assign dbus_be    = dbus_req ? be_raw : 4'b0000;
  assign dbus_addr  = dbus_req ? {mem_alu_result[31:2], 2'b00} : 32'h0;
  assign dbus_wdata = dbus_req ? wdata_raw : 32'h0;

  assign rshift   = dbus_rdata >> {a_lo, 3'b000};
  assign half_sel = a_lo[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  always_comb begin
    load_ext = dbus_rdata;
    if (is_byte)
      load_ext = {{24{is_signed & rshift[7]}}, rshift[7:0]};
    else if (is_half)
      load_ext = {{16{is_signed & half_sel[15]}}, half_sel};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      ldata        <= 32'h0;
      timeout_flag <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_wreg      <= 5'd0;
      wb_wdata     <= 32'h0;
      addr_err     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr_err <= (state == IDLE) & misaligned;
      bus_err  <= timeout_hit;
      if (state == IDLE)     cnt <= 8'd0;
      else if (state == REQ) cnt <= cnt + 8'd1;
      if (ack_hit) begin
        ldata        <= load_ext;
        timeout_flag <= 1'b0;
      end else if (timeout_hit) begin
        ldata        <= 32'h0;
        timeout_flag <= 1'b1;
      end
      if (stall) begin
        wb_RegWrite <= 1'b0;
      end else if (state == DONE) begin
        wb_wreg     <= mem_wreg;
        wb_wdata    <= mem_MemtoReg ? ldata : mem_alu_result;
        wb_RegWrite <= mem_RegWrite & ~timeout_flag;
      end else begin
        wb_wreg     <= mem_wreg;
        wb_wdata    <= mem_lui_sig ? {mem_imme_num[15:0], 16'h0} : mem_alu_result;
        wb_RegWrite <= mem_RegWrite & ~misaligned;
      end
    end
  end

endmodule
`default_nettype wire
